// File: rtl/div_ctrl.sv
// Sequencing controller for the RV32M divide path: handshake, sign handling,
// divide-by-zero/overflow shortcuts, one-entry result cache and flush recovery.
module div_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             div_start,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  input  logic             div_done
);

  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_e;

  state_e           state_q, state_d;
  logic             sel_rem_q, sel_rem_d;
  logic             signed_q, signed_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      dividend_q, dividend_d;
  logic [31:0]      divisor_q, divisor_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             cache_valid_q, cache_valid_d;
  logic             cache_signed_q, cache_signed_d;
  logic [31:0]      cache_a_q, cache_a_d;
  logic [31:0]      cache_b_q, cache_b_d;
  logic [31:0]      cache_quo_q, cache_quo_d;
  logic [31:0]      cache_rem_q, cache_rem_d;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  logic        req_signed, is_div0, is_ovf, cache_hit;
  logic [31:0] fast_quo, fast_rem, mag_a, mag_b, fix_quo, fix_rem;

  assign req_signed = ~req_op[0];
  assign is_div0    = (req_b == 32'd0);
  assign is_ovf     = req_signed && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
  assign cache_hit  = cache_valid_q && (cache_a_q == req_a) && (cache_b_q == req_b)
                      && (cache_signed_q == req_signed);

  // Divide-by-zero wins over overflow, which wins over the cached result.
  assign fast_quo = is_div0 ? 32'hFFFF_FFFF : (is_ovf ? 32'h8000_0000 : cache_quo_q);
  assign fast_rem = is_div0 ? req_a         : (is_ovf ? 32'd0         : cache_rem_q);

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  assign mag_a = (req_signed && req_a[31]) ? neg32(req_a) : req_a;
  assign mag_b = (req_signed && req_b[31]) ? neg32(req_b) : req_b;

  assign fix_quo = (signed_q && (a_q[31] ^ b_q[31])) ? neg32(div_quotient)  : div_quotient;
  assign fix_rem = (signed_q && a_q[31])             ? neg32(div_remainder) : div_remainder;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case infers a latch.
    state_d        = state_q;
    sel_rem_d      = sel_rem_q;
    signed_d       = signed_q;
    a_d            = a_q;
    b_d            = b_q;
    tag_d          = tag_q;
    dividend_d     = dividend_q;
    divisor_d      = divisor_q;
    rsp_data_d     = rsp_data_q;
    cache_valid_d  = cache_valid_q;
    cache_signed_d = cache_signed_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_quo_d    = cache_quo_q;
    cache_rem_d    = cache_rem_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          sel_rem_d = req_op[1];
          signed_d  = req_signed;
          a_d       = req_a;
          b_d       = req_b;
          tag_d     = req_tag;
          if (is_div0 || is_ovf || cache_hit) begin
            rsp_data_d = req_op[1] ? fast_rem : fast_quo;
            state_d    = RESP;
          end else begin
            dividend_d = mag_a;
            divisor_d  = mag_b;
            state_d    = START;
          end
        end
      end
      START: state_d = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush) begin
          state_d = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          cache_valid_d  = 1'b1;
          cache_signed_d = signed_q;
          cache_a_d      = a_q;
          cache_b_d      = b_q;
          cache_quo_d    = fix_quo;
          cache_rem_d    = fix_rem;
          rsp_data_d     = sel_rem_q ? fix_rem : fix_quo;
          state_d        = RESP;
        end
      end
      RESP:    if (flush || rsp_ready) state_d = IDLE;
      DRAIN:   if (div_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sel_rem_q      <= 1'b0;
      signed_q       <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      tag_q          <= '0;
      dividend_q     <= '0;
      divisor_q      <= '0;
      rsp_data_q     <= '0;
      // NOTE: only the valid bit must reset to invalidate the cache; the payload
      // is reset too so the outputs never expose X.
      cache_valid_q  <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
    end else begin
      state_q        <= state_d;
      sel_rem_q      <= sel_rem_d;
      signed_q       <= signed_d;
      a_q            <= a_d;
      b_q            <= b_d;
      tag_q          <= tag_d;
      dividend_q     <= dividend_d;
      divisor_q      <= divisor_d;
      rsp_data_q     <= rsp_data_d;
      cache_valid_q  <= cache_valid_d;
      cache_signed_q <= cache_signed_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_quo_q    <= cache_quo_d;
      cache_rem_q    <= cache_rem_d;
    end
  end

  assign req_ready    = (state_q == IDLE) && !flush;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_data     = rsp_data_q;
  assign rsp_tag      = tag_q;
  assign div_start    = (state_q == START) && !flush;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed vector table, hand-written flush and
// reset sequences, then randomized requests against an arithmetic reference model.
module tb_div_ctrl;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             div_start;
  logic [31:0]      div_dividend, div_divisor;
  logic [31:0]      div_quotient = 32'd0;
  logic [31:0]      div_remainder = 32'd0;
  logic             div_done = 1'b0;

  div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Unsigned restoring-divider stand-in; not reset, so a late done can follow rst.
  int          div_lat = 4;
  int          cnt = 0;
  logic        busy = 1'b0;
  int          start_cnt = 0;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;
  logic [31:0] last_a = 32'd0, last_b = 32'd0;

  always @(negedge clk) begin
    div_done = 1'b0;
    if (busy) begin
      cnt--;
      if (cnt == 0) begin
        div_done      = 1'b1;
        div_quotient  = (op_b == 32'd0) ? 32'hFFFF_FFFF : op_a / op_b;
        div_remainder = (op_b == 32'd0) ? op_a : op_a % op_b;
        busy          = 1'b0;
      end
    end
    if (div_start === 1'b1) begin
      start_cnt++;
      busy   = 1'b1;
      cnt    = div_lat;
      op_a   = div_dividend;
      op_b   = div_divisor;
      last_a = div_dividend;
      last_b = div_divisor;
    end
  end

  // Reference results straight from the RV32M rules.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (32'd0 - x) : x;
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({nm, " ready"}, req_ready, 1);
  endtask

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input string nm);
    wait_ready(nm);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int hold, input logic exp_fast,
                        input logic [31:0] exp_data, input logic [31:0] exp_ma,
                        input logic [31:0] exp_mb, input string nm);
    int cyc, starts0, exp_lat;
    logic stable;
    logic [31:0] d0;
    logic [TAG_W-1:0] t0;
    exp_lat = exp_fast ? 1 : div_lat + 2;
    starts0 = start_cnt;
    accept(op, a, b, tag, nm);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check({nm, " rsp_valid"}, rsp_valid, 1);
    check({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    check({nm, " starts"}, 64'(start_cnt - starts0), exp_fast ? 64'd0 : 64'd1);
    if (!exp_fast) begin
      check({nm, " dividend"}, last_a, exp_ma);
      check({nm, " divisor"}, last_b, exp_mb);
    end
    check({nm, " data"}, rsp_data, exp_data);
    check({nm, " tag"}, rsp_tag, tag);
    d0 = rsp_data; t0 = rsp_tag; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_tag !== t0) stable = 1'b0;
    end
    if (hold > 0) check({nm, " held stable"}, stable, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({nm, " rsp dropped"}, rsp_valid, 0);
    check({nm, " back idle"}, req_ready, 1);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      a, b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
    logic             fast;
    logic [31:0]      ma, mb;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b, exp_d, ma, mb;
    logic        sgn, special, hit, fast, seen;
    logic        m_valid, m_s;
    logic [31:0] m_a, m_b;
    int          starts0, n;

    vecs[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,          5'd1,  32'hFFFF_FFFD, 1'b0, 32'd7,          32'd2};
    vecs[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          5'd2,  32'hFFFF_FFFF, 1'b1, 32'd0,          32'd0};
    vecs[2]  = '{2'b01, 32'd100,       32'd7,          5'd3,  32'd14,        1'b0, 32'd100,        32'd7};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,          5'd4,  32'd2,         1'b1, 32'd0,          32'd0};
    vecs[4]  = '{2'b00, 32'd100,       32'd7,          5'd5,  32'd14,        1'b0, 32'd100,        32'd7};
    vecs[5]  = '{2'b00, 32'd5,         32'd0,          5'd6,  32'hFFFF_FFFF, 1'b1, 32'd0,          32'd0};
    vecs[6]  = '{2'b11, 32'd5,         32'd0,          5'd7,  32'd5,         1'b1, 32'd0,          32'd0};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  5'd8,  32'h8000_0000, 1'b1, 32'd0,          32'd0};
    vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  5'd9,  32'd0,         1'b1, 32'd0,          32'd0};
    vecs[9]  = '{2'b00, 32'h8000_0000, 32'd2,          5'd10, 32'hC000_0000, 1'b0, 32'h8000_0000,  32'd2};
    vecs[10] = '{2'b10, 32'h8000_0000, 32'd2,          5'd11, 32'd0,         1'b1, 32'd0,          32'd0};
    vecs[11] = '{2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  5'd12, 32'd3,         1'b0, 32'd7,          32'd2};
    vecs[12] = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  5'd13, 32'hFFFF_FFFF, 1'b1, 32'd0,          32'd0};
    vecs[13] = '{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  5'd14, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFE};
    vecs[14] = '{2'b01, 32'd0,         32'd3,          5'd15, 32'd0,         1'b0, 32'd0,          32'd3};

    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 0; req_b = 0; req_tag = 0;
    flush = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_tag", rsp_tag, 0);
    check("reset div_start", div_start, 0);
    check("reset div_dividend", div_dividend, 0);
    check("reset div_divisor", div_divisor, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      div_lat = 1 + (i % 5);
      do_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 0, vecs[i].fast, vecs[i].exp,
             vecs[i].ma, vecs[i].mb, $sformatf("vec%0d", i));
    end

    // Response back-pressure: rsp_ready low for 5 cycles.
    div_lat = 3;
    do_req(2'b01, 32'd1000, 32'd7, 5'h15, 5, 1'b0, 32'd142, 32'd1000, 32'd7, "hold");

    // Flush while in START: no div_start pulse, straight back to IDLE.
    starts0 = start_cnt;
    accept(2'b01, 32'd50, 32'd5, 5'h11, "flush_start");
    check("flush_start div_start before flush", div_start, 1);
    flush = 1'b1; #1;
    check("flush_start div_start suppressed", div_start, 0);
    check("flush_start ready low", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; #1;
    check("flush_start rsp_valid", rsp_valid, 0);
    check("flush_start idle", req_ready, 1);
    check("flush_start no pulse", 64'(start_cnt - starts0), 0);

    // Flush two cycles after div_start: drain the divider, no response.
    div_lat = 10;
    accept(2'b01, 32'd50, 32'd5, 5'h12, "flush_wait");
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; #1;
    check("flush_wait ready low in drain", req_ready, 0);
    seen = 1'b0; n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      seen |= (rsp_valid === 1'b1);
      @(posedge clk); #1; n++;
    end
    check("flush_wait no response", seen, 0);
    check("flush_wait ready after done", req_ready, 1);
    check("flush_wait ready with done", div_done, 1);
    div_lat = 2;
    do_req(2'b01, 32'd9, 32'd3, 5'h1A, 0, 1'b0, 32'd3, 32'd9, 32'd3, "after_flush");

    // Flush while in RESP: response dropped.
    accept(2'b00, 32'd5, 32'd0, 5'd3, "flush_resp");
    check("flush_resp rsp_valid", rsp_valid, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; #1;
    check("flush_resp dropped", rsp_valid, 0);
    check("flush_resp idle", req_ready, 1);

    // Cache a result, then reset mid-WAIT and show the cache is gone.
    div_lat = 3;
    do_req(2'b00, 32'd1000, 32'd3, 5'd20, 0, 1'b0, 32'd333, 32'd1000, 32'd3, "cache_fill");
    do_req(2'b10, 32'd1000, 32'd3, 5'd21, 0, 1'b1, 32'd1, 32'd0, 32'd0, "cache_hit");
    div_lat = 8;
    accept(2'b01, 32'd77, 32'd5, 5'd22, "rst_wait");
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("async rst rsp_valid", rsp_valid, 0);
    check("async rst rsp_data", rsp_data, 0);
    check("async rst rsp_tag", rsp_tag, 0);
    check("async rst div_start", div_start, 0);
    check("async rst div_dividend", div_dividend, 0);
    check("async rst div_divisor", div_divisor, 0);
    check("async rst req_ready", req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0; n = 0;
    while (busy && n < 50) begin
      seen |= (rsp_valid === 1'b1);
      @(posedge clk); #1; n++;
    end
    repeat (2) begin
      seen |= (rsp_valid === 1'b1);
      @(posedge clk); #1;
    end
    check("late done ignored", seen, 0);
    div_lat = 3;
    do_req(2'b00, 32'd1000, 32'd3, 5'd23, 0, 1'b0, 32'd333, 32'd1000, 32'd3, "post_rst_miss");

    // Randomized requests against the reference model.
    rst = 1'b1; #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_valid = 1'b0; m_s = 1'b0; m_a = 0; m_b = 0;
    a = 0; b = 0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 || i == 0) begin
        for (int k = 0; k < 2; k++) begin
          logic [31:0] v;
          case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 20));
            4:       v = $urandom;
            default: v = 32'd0 - 32'($urandom_range(1, 20));
          endcase
          if (k == 0) a = v; else b = v;
        end
      end
      sgn     = ~op[0];
      special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      hit     = m_valid && m_a == a && m_b == b && m_s == sgn;
      fast    = special || hit;
      exp_d   = ref_result(op, a, b);
      ma      = sgn ? abs32(a) : a;
      mb      = sgn ? abs32(b) : b;
      div_lat = $urandom_range(1, 8);
      do_req(op, a, b, 5'($urandom), $urandom_range(0, 2), fast, exp_d, ma, mb,
             $sformatf("rnd%0d op%0d %h/%h", i, op, a, b));
      if (!fast) begin
        m_valid = 1'b1; m_s = sgn; m_a = a; m_b = b;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
